draw_rect_char: RTL
===================

# draw_rect_char

Text-overlay stage in the VGA pixel pipeline that renders a rectangular grid of 8x16 font characters onto the incoming video stream. It consumes the VGA timing bus produced by the timing generator, or by the previous draw stage, together with the shared geometry and colour constants from `vga_pkg`. It drives two external synchronous lookups: the text-buffer ROM (character code per cell) and the font ROM (pixel row per glyph line). It emits the same bus, delayed by a fixed latency, with glyph pixels overlaid.

## Interface
Parameters:
- `XPOS`, `vga_pkg::RECT_X` (600): left edge of the text box, in pixels.
- `YPOS`, `vga_pkg::RECT_Y` (100): top edge of the text box, in lines.
- `COLS`, 16: characters per row; legal range 1..16.
- `ROWS`, 16: character rows; legal range 1..16.
- `FG`, `vga_pkg::L_COLOR` (12'hEFF): glyph colour.
- `BG`, `vga_pkg::BG_COLOR` (12'h60D): box background colour. Used only with `TEXT_BG_EN`.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `hcount_in`, `vcount_in` in 11 each: pixel position.
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in` in 1 each: sync and blanking.
- `rgb_in` in 12: upstream colour, 12'hRGB.
- `hcount_out`, `vcount_out`, `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out`, `rgb_out` out: the delayed bus, same widths as the inputs.
- `char_xy` out 8: text-buffer address {row[3:0], col[3:0]}.
- `char_code` in 7: ASCII code returned by the text-buffer ROM.
- `char_line` out 11: font address {char_code[6:0], line[3:0]}.
- `char_pixels` in 8: font row; bit 7 is the leftmost pixel.

## Operation
- Geometry, computed as 11-bit unsigned values:
  - rel_x = hcount − XPOS; rel_y = vcount − YPOS.
  - A pixel is inside the box iff XPOS ≤ hcount ≤ XPOS+8·COLS−1 and YPOS ≤ vcount ≤ YPOS+16·ROWS−1.
  - col = rel_x[6:3], xbit = rel_x[2:0], row = rel_y[7:4], line = rel_y[3:0].
- Four-stage pipeline, S1 to S4. Every stage registers the full timing bus, rgb, and an `inside` flag.
  - S1 registers `char_xy` = {row, col} when inside, 8'h00 when outside. It also registers xbit and line.
  - The text-buffer ROM returns `char_code` one cycle after `char_xy`.
  - S2 forwards xbit and line. `char_line` = {char_code, S2.line} is combinational.
  - The font ROM returns `char_pixels` one cycle after `char_line`.
  - S3 forwards xbit.
  - S4 is the output register. It selects `pix = char_pixels[7 − S3.xbit]`.
- Colour select at S4:
  - If hblnk or vblnk is set: `rgb_out` = 12'h000.
  - Else if inside and pix = 1: `rgb_out` = FG.
  - Else if inside and pix = 0: `rgb_out` = BG with `TEXT_BG_EN`, otherwise the delayed rgb.
  - Else: the delayed rgb.
- Sync, blank and count signals pass through unmodified, only delayed.
- Position rules:
  - Positions left of or above the box wrap to large unsigned values and must evaluate as outside.
  - Positions during blanking must not set `inside`.

## Timing
- Latency is 4 cycles from any `*_in` to the matching `*_out`. All bus outputs share this latency exactly.
- `char_xy` is valid 1 cycle after input. `char_line` is valid 2 cycles after input.
- Both ROMs must have exactly 1-cycle read latency. No handshake is used; a new address is accepted every cycle.
- Reset:
  - While `rst_n` = 0 at a rising edge, all pipeline registers clear. All outputs read 0, including `char_xy`, `char_line` and the syncs.
  - After deassertion, outputs stay 0 for 4 cycles until real data reaches S4.
  - Reset asserted mid-line or mid-frame takes effect at the next edge; no partial glyph survives it.
- Box boundaries: the last column ends at pixel XPOS+8·COLS−1 with xbit = 7. Pixel XPOS+8·COLS is outside, even when hblnk = 0.
- A box extending past the active area is legal; blanking overrides it.

## Configuration
- `TEXT_BG_EN` defined: non-glyph pixels inside the box are painted BG. This gives a solid text panel.
- `TEXT_BG_EN` undefined: non-glyph pixels show `rgb_in` delayed; only glyph pixels are overwritten. BG is unused and no BG logic is synthesised.

## Test plan
- Reset hold: `rst_n` = 0 for 5 cycles with `rgb_in` = 12'hFFF. All outputs are 0 throughout and for 4 cycles after release.
- Latency: ramp `hcount_in` 0..1649 with a sync pulse. `hcount_out` and `hsync_out` equal the inputs from 4 cycles earlier.
- Address generation: at hcount = 600+8·3+5, vcount = 100+16·2+9, expect `char_xy` = 8'h23 one cycle later. With `char_code` = 7'h41 returned, expect `char_line` = 11'h419.
- Glyph pixel: `char_pixels` = 8'b1000_0001, `rgb_in` = 12'h123, no blanking. For xbit 0 and 7, `rgb_out` = 12'hEFF. For xbit 1 to 6, `rgb_out` = 12'h60D with `TEXT_BG_EN`, 12'h123 without.
- Boundaries: hcount = 599 and 728, and vcount = 99 and 356, give `rgb_out` = delayed `rgb_in`. hcount = 600 and 727 give inside.
- Blanking and mid-frame reset: `hblnk_in` = 1 inside the box gives `rgb_out` = 0. `rst_n` pulsed low for 1 cycle mid-line zeroes outputs on the next edge, and normal output resumes 4 cycles after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry, colour constants and the pipeline bus payload.
//   RECT_X / RECT_Y    : default text box origin (pixels / lines)
//   L_COLOR / BG_COLOR : default glyph and panel colours, 12'hRGB
//   vga_bus_t          : timing bus plus colour carried through draw stages
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  localparam logic [CNT_W-1:0] RECT_X   = 11'd600;
  localparam logic [CNT_W-1:0] RECT_Y   = 11'd100;
  localparam logic [RGB_W-1:0] L_COLOR  = 12'hEFF;
  localparam logic [RGB_W-1:0] BG_COLOR = 12'h60D;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/draw_rect_char.sv
// Text-overlay stage: renders a COLS x ROWS grid of 8x16 glyphs at (XPOS, YPOS)
// on top of the incoming VGA stream. Four-stage pipeline, latency 4.
//
// Ports:
//   clk, rst_n                      pixel clock, synchronous active-low reset
//   hcount_in .. rgb_in             upstream timing bus and colour
//   hcount_out .. rgb_out           same bus delayed by 4 cycles, glyphs overlaid
//   char_xy     (out, 8)            text-buffer address {row, col}, 1 cycle after input
//   char_code   (in, 7)             text-buffer ROM data, 1 cycle after char_xy
//   char_line   (out, 11)           font address {char_code, line}, combinational
//   char_pixels (in, 8)             font ROM row, bit 7 = leftmost pixel
//
// Configuration macro: TEXT_BG_EN -- when defined, non-glyph pixels inside the
// box are painted BG; when undefined they keep the delayed upstream colour.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [CNT_W-1:0] XPOS = RECT_X,
  parameter logic [CNT_W-1:0] YPOS = RECT_Y,
  parameter int unsigned      COLS = 16,
  parameter int unsigned      ROWS = 16,
  parameter logic [RGB_W-1:0] FG   = L_COLOR,
  parameter logic [RGB_W-1:0] BG   = BG_COLOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [7:0]       char_xy,
  input  logic [6:0]       char_code,
  output logic [10:0]      char_line,
  input  logic [7:0]       char_pixels
);

  localparam logic [CNT_W-1:0] BOX_W = CNT_W'(8 * COLS);
  localparam logic [CNT_W-1:0] BOX_H = CNT_W'(16 * ROWS);

  vga_bus_t         in_bus;
  vga_bus_t         s1_bus, s2_bus, s3_bus, s4_bus;
  logic             s1_inside, s2_inside, s3_inside;
  logic [2:0]       s1_xbit, s2_xbit, s3_xbit;
  logic [3:0]       s1_line, s2_line;
  logic             s1_vld, s2_vld;
  logic [7:0]       xy_q;

  logic [CNT_W-1:0] rel_x, rel_y;
  logic             in_box;
  logic             pix;
  logic [RGB_W-1:0] rgb_next;

  assign in_bus = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};

  // Box test on wrapped unsigned offsets: positions left of / above the box
  // become huge and fail the upper-bound compare.
  always_comb begin
    rel_x  = hcount_in - XPOS;
    rel_y  = vcount_in - YPOS;
    in_box = (rel_x < BOX_W) && (rel_y < BOX_H) && !hblnk_in && !vblnk_in;
  end

  // S1: text-buffer address plus glyph coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_bus    <= '0;
      s1_inside <= 1'b0;
      s1_xbit   <= '0;
      s1_line   <= '0;
      s1_vld    <= 1'b0;
      xy_q      <= '0;
    end else begin
      s1_bus    <= in_bus;
      s1_inside <= in_box;
      s1_xbit   <= rel_x[2:0];
      s1_line   <= rel_y[3:0];
      s1_vld    <= 1'b1;
      xy_q      <= in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
    end
  end

  // S2: char_code arrives alongside this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_bus    <= '0;
      s2_inside <= 1'b0;
      s2_xbit   <= '0;
      s2_line   <= '0;
      s2_vld    <= 1'b0;
    end else begin
      s2_bus    <= s1_bus;
      s2_inside <= s1_inside;
      s2_xbit   <= s1_xbit;
      s2_line   <= s1_line;
      s2_vld    <= s1_vld;
    end
  end

  // Font address is held at zero until real data occupies S2, so the ROM's
  // output cannot leak onto char_line during or just after reset.
  assign char_line = s2_vld ? {char_code, s2_line} : 11'h000;
  assign char_xy   = xy_q;

  // S3: char_pixels arrives alongside this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_bus    <= '0;
      s3_inside <= 1'b0;
      s3_xbit   <= '0;
    end else begin
      s3_bus    <= s2_bus;
      s3_inside <= s2_inside;
      s3_xbit   <= s2_xbit;
    end
  end

  // Colour select: blanking wins, then glyph pixel, then panel / passthrough.
  always_comb begin
    pix      = char_pixels[3'd7 - s3_xbit];
    rgb_next = s3_bus.rgb;
    if (s3_bus.hblnk || s3_bus.vblnk) begin
      rgb_next = '0;
    end else if (s3_inside && pix) begin
      rgb_next = FG;
    end
`ifdef TEXT_BG_EN
    else if (s3_inside) begin
      rgb_next = BG;
    end
`endif
  end

  // S4: output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s4_bus <= '0;
    end else begin
      s4_bus     <= s3_bus;
      s4_bus.rgb <= rgb_next;
    end
  end

  assign hcount_out = s4_bus.hcount;
  assign vcount_out = s4_bus.vcount;
  assign hsync_out  = s4_bus.hsync;
  assign hblnk_out  = s4_bus.hblnk;
  assign vsync_out  = s4_bus.vsync;
  assign vblnk_out  = s4_bus.vblnk;
  assign rgb_out    = s4_bus.rgb;

endmodule
